axis_xfer_engine: RTL and testbench

Parametrised AXI-Stream transfer engine placed between the DPI-C testbench tasks and the GEMM `top` stream ports. It buffers a frame written by the host side and plays it out as an AXI-Stream master, honouring TREADY backpressure and generating TLAST. It also captures a response frame from the DUT's AXI-Stream master into a buffer that the host reads back by address. It replaces fixed 64-word, ready-blind send/receive with length-programmed, handshake-correct transfers and status reporting.

---
 rtl/axis_xfer_engine.sv | 213 +++++++++++++++++++++
 tb/tb_axis_xfer_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_xfer_engine.sv
// AXI-Stream transfer engine: host-filled TX buffer played out as a stream master,
// and a length-limited RX capture buffer read back by address. Optional AXIS_TLAST_CHECK_EN.
module axis_xfer_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int LEN_W  = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [LEN_W-1:0]         tx_count,
  output logic                     tx_ovf,
  input  logic                     tx_start,
  input  logic [LEN_W-1:0]         tx_len,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     tx_err,
  input  logic                     rx_arm,
  input  logic [LEN_W-1:0]         rx_len,
  output logic [LEN_W-1:0]         rx_count,
  output logic                     rx_done,
  output logic                     rx_lasterr,
  input  logic [$clog2(DEPTH)-1:0] rx_rd_addr,
  output logic [DATA_W-1:0]        rx_rd_data,
  output logic                     M_AXIS_TVALID,
  output logic [DATA_W-1:0]        M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]      M_AXIS_TSTRB,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY,
  input  logic                     S_AXIS_TVALID,
  input  logic [DATA_W-1:0]        S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]      S_AXIS_TSTRB,
  input  logic                     S_AXIS_TLAST,
  output logic                     S_AXIS_TREADY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [AW-1:0]    ADDR0   = '0;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_ARMED}         rx_state_e;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];

  // ---------------- TX path ----------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [LEN_W-1:0]  tx_count_q, tx_ptr_q, tx_len_q, tx_ptr_nxt;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_ovf_q, tx_err_q;
  logic              tx_push, tx_drop, tx_accept, tx_reject, tx_hs, tx_last;

  assign M_AXIS_TVALID = (tx_state_q == TX_SEND);
  assign tx_last       = (tx_ptr_q == tx_len_q - ONE);
  assign M_AXIS_TLAST  = M_AXIS_TVALID && tx_last;
  assign M_AXIS_TDATA  = tx_data_q;
  assign M_AXIS_TSTRB  = '1;
  assign tx_hs         = M_AXIS_TVALID && M_AXIS_TREADY;
  assign tx_ptr_nxt    = tx_ptr_q + ONE;
  assign tx_busy       = M_AXIS_TVALID;
  assign tx_done       = (tx_state_q == TX_DONE);
  assign tx_count      = tx_count_q;
  assign tx_ovf        = tx_ovf_q;
  assign tx_err        = tx_err_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_push    = 1'b0;
    tx_drop    = 1'b0;
    tx_accept  = 1'b0;
    tx_reject  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (wr_en) begin
          tx_push = (tx_count_q < DEPTH_L);
          tx_drop = !tx_push;
        end
        // Length is checked against the count before any same-cycle write.
        if (tx_start) begin
          if ((tx_len != '0) && (tx_len <= tx_count_q)) begin
            tx_accept  = 1'b1;
            tx_state_d = TX_SEND;
          end else begin
            tx_reject = 1'b1;
          end
        end
      end
      TX_SEND: begin
        tx_drop   = wr_en;
        tx_reject = tx_start;
        if (tx_hs && tx_last) tx_state_d = TX_DONE;
      end
      TX_DONE: begin
        tx_drop    = wr_en;
        tx_reject  = tx_start;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_count_q <= '0;
      tx_ptr_q   <= '0;
      tx_len_q   <= '0;
      tx_data_q  <= '0;
      tx_ovf_q   <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_err_q   <= tx_reject;
      if (tx_drop) tx_ovf_q <= 1'b1;
      if (tx_state_q == TX_DONE) tx_count_q <= '0;
      else if (tx_push)          tx_count_q <= tx_count_q + ONE;
      // TDATA is a register preloaded with the next beat, so it holds while stalled.
      if (tx_accept) begin
        tx_ptr_q  <= '0;
        tx_len_q  <= tx_len;
        tx_data_q <= tx_mem[ADDR0];
      end else if (tx_hs && !tx_last) begin
        tx_ptr_q  <= tx_ptr_nxt;
        tx_data_q <= tx_mem[tx_ptr_nxt[AW-1:0]];
      end
    end
  end

  // NOTE: buffer storage has no reset; the counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push && !reset) tx_mem[tx_count_q[AW-1:0]] <= wr_data;
  end

  // ---------------- RX path ----------------
  rx_state_e         rx_state_q, rx_state_d;
  logic [LEN_W-1:0]  rx_count_q, rx_len_q, rx_count_inc;
  logic [DATA_W-1:0] rx_rd_data_q;
  logic              rx_done_q, rx_hs, rx_end, rx_lerr_set;

  assign S_AXIS_TREADY = (rx_state_q == RX_ARMED) && (rx_count_q < rx_len_q);
  assign rx_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rx_count_inc  = rx_count_q + ONE;
  assign rx_count      = rx_count_q;
  assign rx_done       = rx_done_q;
  assign rx_rd_data    = rx_rd_data_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_end      = 1'b0;
    rx_lerr_set = 1'b0;
    // A re-arm restarts the capture; a word handshaken in that same cycle is discarded.
    if (rx_arm) begin
      rx_end     = (rx_len == '0);
      rx_state_d = rx_end ? RX_IDLE : RX_ARMED;
    end else if (rx_hs) begin
`ifdef AXIS_TLAST_CHECK_EN
      rx_end      = S_AXIS_TLAST || (rx_count_inc == rx_len_q);
      rx_lerr_set = (S_AXIS_TLAST && (rx_count_inc < rx_len_q)) ||
                    (!S_AXIS_TLAST && (rx_count_inc == rx_len_q));
`else
      rx_end      = (rx_count_inc == rx_len_q);
`endif
      if (rx_end) rx_state_d = RX_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_count_q   <= '0;
      rx_len_q     <= '0;
      rx_done_q    <= 1'b0;
      rx_rd_data_q <= '0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_done_q    <= rx_end;
      rx_rd_data_q <= rx_mem[rx_rd_addr];
      if (rx_arm) begin
        rx_count_q <= '0;
        rx_len_q   <= (rx_len > DEPTH_L) ? DEPTH_L : rx_len;
      end else if (rx_hs) begin
        rx_count_q <= rx_count_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_hs && !rx_arm && !reset) rx_mem[rx_count_q[AW-1:0]] <= S_AXIS_TDATA;
  end

`ifdef AXIS_TLAST_CHECK_EN
  logic rx_lasterr_q;
  always_ff @(posedge clk) begin
    if (reset || rx_arm) rx_lasterr_q <= 1'b0;
    else if (rx_lerr_set) rx_lasterr_q <= 1'b1;
  end
  assign rx_lasterr = rx_lasterr_q;

  logic unused_ok;
  assign unused_ok = ^S_AXIS_TSTRB;
`else
  assign rx_lasterr = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{S_AXIS_TSTRB, S_AXIS_TLAST, rx_lerr_set};
`endif

endmodule

// File: tb/tb_axis_xfer_engine.sv
// Directed self-checking bench for axis_xfer_engine (DATA_W=32, DEPTH=64).
module tb_axis_xfer_engine;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [LEN_W-1:0]  tx_count;
  logic              tx_ovf;
  logic              tx_start = 1'b0;
  logic [LEN_W-1:0]  tx_len = '0;
  logic              tx_busy, tx_done, tx_err;
  logic              rx_arm = 1'b0;
  logic [LEN_W-1:0]  rx_len = '0;
  logic [LEN_W-1:0]  rx_count;
  logic              rx_done, rx_lasterr;
  logic [$clog2(DEPTH)-1:0] rx_rd_addr = '0;
  logic [DATA_W-1:0] rx_rd_data;
  logic              M_AXIS_TVALID, M_AXIS_TLAST;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic [DATA_W/8-1:0] M_AXIS_TSTRB;
  logic              M_AXIS_TREADY = 1'b0;
  logic              S_AXIS_TVALID = 1'b0;
  logic [DATA_W-1:0] S_AXIS_TDATA = '0;
  logic [DATA_W/8-1:0] S_AXIS_TSTRB = '0;
  logic              S_AXIS_TLAST = 1'b0;
  logic              S_AXIS_TREADY;

  axis_xfer_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .tx_count(tx_count), .tx_ovf(tx_ovf),
    .tx_start(tx_start), .tx_len(tx_len), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .rx_arm(rx_arm), .rx_len(rx_len), .rx_count(rx_count), .rx_done(rx_done),
    .rx_lasterr(rx_lasterr), .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_tx   [DEPTH];
  logic [DATA_W-1:0] src_data [16];
  logic              src_last [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Starts a frame of len beats from exp_tx[] and checks it beat by beat.
  task automatic run_tx(input int len, input bit stall, input string tag);
    int  beat = 0;
    int  cyc  = 1;
    bit  done = 0;
    bit  stalled = 0;
    logic [DATA_W-1:0] held_d = '0;
    logic              held_l = 1'b0;
    tx_len = LEN_W'(len); tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    while (!done && cyc <= 400) begin
      M_AXIS_TREADY = stall ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
      if (tx_done) begin
        done = 1;
        check({tag, " beats"}, beat, len);
        if (!stall) check({tag, " done_cycle"}, cyc, len + 1);
        check({tag, " valid_after"}, M_AXIS_TVALID, 0);
      end else begin
        check({tag, " valid"}, M_AXIS_TVALID, 1);
        if (stalled) begin
          check({tag, " hold_data"}, M_AXIS_TDATA, held_d);
          check({tag, " hold_last"}, M_AXIS_TLAST, held_l);
        end
        if (M_AXIS_TREADY) begin
          check({tag, " data"}, M_AXIS_TDATA, exp_tx[beat]);
          check({tag, " last"}, M_AXIS_TLAST, beat == len - 1);
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          held_d  = M_AXIS_TDATA;
          held_l  = M_AXIS_TLAST;
        end
        tick();
        cyc++;
      end
    end
    if (!done) check({tag, " timeout"}, 0, 1);
    M_AXIS_TREADY = 1'b1;
    tick();
    check({tag, " count_clear"}, tx_count, 0);
    check({tag, " done_pulse"}, tx_done, 0);
  endtask

  // Arms a capture of len words; the source offers src_n words from src_data/src_last.
  task automatic run_rx(input int len, input int src_n, input int exp_cnt,
                        input bit exp_lerr, input string tag);
    int idx = 0;
    int guard = 0;
    bit done = 0;
    rx_len = LEN_W'(len); rx_arm = 1'b1;
    tick();
    rx_arm = 1'b0;
    while (!done && guard < 100) begin
      S_AXIS_TVALID = (idx < src_n);
      S_AXIS_TDATA  = src_data[idx];
      S_AXIS_TLAST  = src_last[idx];
      if (rx_done) begin
        done = 1;
      end else begin
        if (S_AXIS_TVALID && S_AXIS_TREADY) idx++;
        tick();
        guard++;
      end
    end
    check({tag, " done_seen"}, done, 1);
    check({tag, " count"}, rx_count, exp_cnt);
    check({tag, " ready_low"}, S_AXIS_TREADY, 0);
    check({tag, " consumed"}, idx, exp_cnt);
    check({tag, " lasterr"}, rx_lasterr, exp_lerr);
    tick();
    tick();
    check({tag, " ready_stays_low"}, S_AXIS_TREADY, 0);
    check({tag, " done_pulse"}, rx_done, 0);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    for (int i = 0; i < exp_cnt; i++) begin
      rx_rd_addr = i[$clog2(DEPTH)-1:0];
      tick();
      check({tag, " rd_data"}, rx_rd_data, src_data[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst tvalid", M_AXIS_TVALID, 0);
    check("rst tlast", M_AXIS_TLAST, 0);
    check("rst tdata", M_AXIS_TDATA, 0);
    check("rst tstrb", M_AXIS_TSTRB, 4'hF);
    check("rst s_tready", S_AXIS_TREADY, 0);
    check("rst rd_data", rx_rd_data, 0);
    check("rst counts", {tx_count, rx_count}, 0);
    check("rst flags", {tx_busy, tx_done, tx_err, tx_ovf, rx_done, rx_lasterr}, 0);
    reset = 1'b0;
    tick();

    // 4-word frame, no backpressure
    for (int i = 0; i < 4; i++) begin
      exp_tx[i] = 32'h11 * (i + 1);
      push(exp_tx[i]);
    end
    check("fill4 count", tx_count, 4);
    run_tx(4, 1'b0, "tx4");

    // Same frame with TREADY 1,0,0,1,...
    for (int i = 0; i < 4; i++) push(exp_tx[i]);
    run_tx(4, 1'b1, "tx4_stall");

    // Rejected starts, then a short frame discarding the extra word
    for (int i = 0; i < 3; i++) begin
      exp_tx[i] = 32'(i + 1);
      push(exp_tx[i]);
    end
    tx_len = 5; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("len5 err", tx_err, 1);
    check("len5 novalid", M_AXIS_TVALID, 0);
    check("len5 count", tx_count, 3);
    tick();
    check("len5 err_pulse", tx_err, 0);
    tx_len = 0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("len0 err", tx_err, 1);
    check("len0 novalid", M_AXIS_TVALID, 0);
    run_tx(2, 1'b0, "tx2_of3");

    // Fill to DEPTH, then one overflow push, then send all 64
    for (int i = 0; i < DEPTH; i++) begin
      exp_tx[i] = 32'h1000 + 32'(i);
      push(exp_tx[i]);
    end
    check("full count", tx_count, DEPTH);
    check("full no_ovf", tx_ovf, 0);
    push(32'hDEAD);
    check("ovf count", tx_count, DEPTH);
    check("ovf flag", tx_ovf, 1);
    run_tx(DEPTH, 1'b0, "tx64");

    // Write and start together on an empty buffer: start sees count 0
    wr_en = 1'b1; wr_data = 32'hCAFE; tx_len = 1; tx_start = 1'b1;
    tick();
    wr_en = 1'b0; tx_start = 1'b0;
    check("same_cycle err", tx_err, 1);
    check("same_cycle count", tx_count, 1);
    exp_tx[0] = 32'hCAFE;
    run_tx(1, 1'b0, "tx1");

    // RX: limit 3, source offers 4
    src_data[0] = 32'hA; src_data[1] = 32'hB; src_data[2] = 32'hC; src_data[3] = 32'hD;
    for (int i = 0; i < 16; i++) src_last[i] = 1'b0;
    run_rx(3, 4, 3, 1'b0, "rx3");

    // RX: zero length completes immediately
    rx_len = 0; rx_arm = 1'b1;
    tick();
    rx_arm = 1'b0;
    check("rx0 done", rx_done, 1);
    check("rx0 ready", S_AXIS_TREADY, 0);
    check("rx0 count", rx_count, 0);

    // RX: limit 8, TLAST on the 3rd word
    for (int i = 0; i < 8; i++) begin
      src_data[i] = 32'h100 + 32'(i);
      src_last[i] = (i == 2);
    end
`ifdef AXIS_TLAST_CHECK_EN
    run_rx(8, 8, 3, 1'b1, "rx_tlast");
`else
    run_rx(8, 8, 8, 1'b0, "rx_tlast");
`endif

    // Reset while beat 2 of an 8-beat frame is on the bus
    for (int i = 0; i < 8; i++) begin
      exp_tx[i] = 32'h80 + 32'(i);
      push(exp_tx[i]);
    end
    M_AXIS_TREADY = 1'b1;
    tx_len = 8; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tick();
    tick();
    check("midrst beat2", M_AXIS_TDATA, 32'h82);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst tvalid", M_AXIS_TVALID, 0);
    check("midrst busy", tx_busy, 0);
    check("midrst count", tx_count, 0);
    exp_tx[0] = 32'h55; exp_tx[1] = 32'h66;
    push(exp_tx[0]);
    push(exp_tx[1]);
    run_tx(2, 1'b0, "tx_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
